id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL: clock and reset are fixed as one clock, synchronous active-high reset.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
REQ-002 SHALL: decode-side inputs are as follows.
- valid_ID  in  1  IF/ID holds a real instruction
- read_reg1_ID / read_reg2_ID  in  3 each  source register numbers
- use_r1_ID / use_r2_ID  in  1 each  instruction actually reads that source
- rs_ID / r2_ID  in  16 each  register-file read data
- imm_ID  in  16  extended immediate
- w1_reg_ID  in  3  destination register
- reg_en_ID, mem_en_ID, mem_wr_ID, b_sel_ID, halt_ID  in  1 each  decoded controls
- alu_op_ID  in  5  ALU opcode
- flush_EX  in  1  taken branch/jump resolved in EX this cycle
REQ-003 SHALL: ID/EX register outputs are valid_ID_EX, read_reg1_ID_EX, read_reg2_ID_EX, rs_ID_EX, r2_ID_EX, imm_ID_EX, w1_reg_ID_EX, reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX, b_sel_ID_EX, alu_op_ID_EX (out, widths as inputs), all registered; these feed the EX-stage forwarding unit.
REQ-004 SHALL: status outputs are as follows.
- stall  out  1  combinational; hold PC and IF/ID
- halted  out  1  registered, sticky
- stall_count  out  16  registered; saturating count of stall cycles

Function
REQ-005 SHALL: load_use = valid_ID & valid_ID_EX & mem_en_ID_EX & ~mem_wr_ID_EX & reg_en_ID_EX & ((use_r1_ID & read_reg1_ID==w1_reg_ID_EX) | (use_r2_ID & read_reg2_ID==w1_reg_ID_EX)).
REQ-006 SHALL: stall = (load_use | halted) & ~flush_EX.
REQ-007 SHALL: the next ID/EX content is selected by priority rst > flush_EX > halted > load_use > normal.
REQ-008 SHALL: a bubble sets valid and every control/enable bit to 0, and all data and register fields to 0.
REQ-009 SHALL: normal operation copies every *_ID input to its *_ID_EX output, with valid_ID_EX = valid_ID and all controls ANDed with valid_ID.
REQ-010 SHALL: flush_EX loads a bubble, and takes priority over a simultaneous load_use (stall=0 that cycle).
REQ-011 SHALL: load_use loads a bubble.
- Stall lasts exactly 1 cycle per load-use pair, since the bubble clears the condition.
- The held instruction enters ID/EX the next cycle; the EX forwarding unit supplies the load result from MEM/WB.
REQ-012 SHALL: halted is set on the edge that registers a valid halt_ID into ID/EX (normal path only), and is cleared only by rst.
REQ-013 SHALL: while halted=1, ID/EX loads bubbles each cycle and stall=1, unless flush_EX is asserted that cycle.
REQ-014 SHALL: the halt instruction itself still reaches ID/EX with halt-related controls as decoded.
REQ-015 SHALL: stall_count increments by 1 on each edge where stall=1 and holds at 16'hFFFF.
REQ-016 SHALL: a load followed by a store that reads the loaded register via r2 only (use_r2_ID=0 for store data) does not stall; that case is handled by the downstream LD-to-ST forwarding.
REQ-017 SHALL: register r0 has no special treatment; matches on register 0 stall like any other register.

Reset
REQ-018 SHALL: on rst, all ID/EX outputs are 0, halted=0 and stall_count=0 on the following edge.
REQ-019 SHALL: stall is 0 while the registers are in reset state.
REQ-020 SHALL: rst mid-stall or mid-halt discards the held state with no residual bubble or stall.

Verification
REQ-021 SHALL: LD r3 (mem_en=1, mem_wr=0, reg_en=1, w1=3) followed by ADD with read_reg1_ID=3 and use_r1=1 -> stall=1 for 1 cycle, one bubble (valid_ID_EX=0), ADD in ID/EX next cycle, stall_count=1.
REQ-022 SHALL: LD r3 followed by ADD reading r4/r5 -> stall=0, no bubble, back-to-back issue.
REQ-023 SHALL: load_use and flush_EX asserted in the same cycle -> stall=0, bubble loaded, stall_count unchanged.
REQ-024 SHALL: valid HALT issued -> halted=1 the edge after it registers, stall=1, valid_ID_EX=0 every later cycle, stall_count saturates at FFFF after 65535 cycles.
REQ-025 SHALL: rst asserted during halted -> all outputs 0, halted=0, stall=0 the next cycle, normal issue resumes.
REQ-026 SHALL: valid_ID=0 with reg_en_ID=1, mem_en_ID=1 -> ID/EX controls all 0 and no stall from that slot.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and a sticky halt.
// All outputs are registered except stall, which is derived from the current decode slot.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,

    input  logic        valid_ID,
    input  logic [2:0]  read_reg1_ID,
    input  logic [2:0]  read_reg2_ID,
    input  logic        use_r1_ID,
    input  logic        use_r2_ID,
    input  logic [15:0] rs_ID,
    input  logic [15:0] r2_ID,
    input  logic [15:0] imm_ID,
    input  logic [2:0]  w1_reg_ID,
    input  logic        reg_en_ID,
    input  logic        mem_en_ID,
    input  logic        mem_wr_ID,
    input  logic        b_sel_ID,
    input  logic        halt_ID,
    input  logic [4:0]  alu_op_ID,
    input  logic        flush_EX,

    output logic        valid_ID_EX,
    output logic [2:0]  read_reg1_ID_EX,
    output logic [2:0]  read_reg2_ID_EX,
    output logic [15:0] rs_ID_EX,
    output logic [15:0] r2_ID_EX,
    output logic [15:0] imm_ID_EX,
    output logic [2:0]  w1_reg_ID_EX,
    output logic        reg_en_ID_EX,
    output logic        mem_en_ID_EX,
    output logic        mem_wr_ID_EX,
    output logic        b_sel_ID_EX,
    output logic [4:0]  alu_op_ID_EX,

    output logic        stall,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } halt_state_t;

    halt_state_t state;
    halt_state_t state_next;

    logic ex_is_load;
    logic r1_hit;
    logic r2_hit;
    logic load_use;
    logic bubble;
    logic take_halt;

    assign halted = (state == HALTED);

    // Only a real, register-writing load in EX can create a hazard; r0 is not special.
    assign ex_is_load = valid_ID_EX & mem_en_ID_EX & ~mem_wr_ID_EX & reg_en_ID_EX;
    assign r1_hit     = use_r1_ID & (read_reg1_ID == w1_reg_ID_EX);
    assign r2_hit     = use_r2_ID & (read_reg2_ID == w1_reg_ID_EX);
    assign load_use   = valid_ID & ex_is_load & (r1_hit | r2_hit);

    assign stall      = (load_use | halted) & ~flush_EX;
    assign bubble     = flush_EX | halted | load_use;
    assign take_halt  = ~bubble & valid_ID & halt_ID;

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (take_halt) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Reset and every bubble source produce the same all-zero slot.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_ID_EX     <= 1'b0;
            read_reg1_ID_EX <= 3'd0;
            read_reg2_ID_EX <= 3'd0;
            rs_ID_EX        <= 16'd0;
            r2_ID_EX        <= 16'd0;
            imm_ID_EX       <= 16'd0;
            w1_reg_ID_EX    <= 3'd0;
            reg_en_ID_EX    <= 1'b0;
            mem_en_ID_EX    <= 1'b0;
            mem_wr_ID_EX    <= 1'b0;
            b_sel_ID_EX     <= 1'b0;
            alu_op_ID_EX    <= 5'd0;
        end else begin
            valid_ID_EX     <= valid_ID;
            read_reg1_ID_EX <= read_reg1_ID;
            read_reg2_ID_EX <= read_reg2_ID;
            rs_ID_EX        <= rs_ID;
            r2_ID_EX        <= r2_ID;
            imm_ID_EX       <= imm_ID;
            w1_reg_ID_EX    <= w1_reg_ID;
            reg_en_ID_EX    <= reg_en_ID & valid_ID;
            mem_en_ID_EX    <= mem_en_ID & valid_ID;
            mem_wr_ID_EX    <= mem_wr_ID & valid_ID;
            b_sel_ID_EX     <= b_sel_ID & valid_ID;
            alu_op_ID_EX    <= alu_op_ID & {5{valid_ID}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage; a reference model fills a scoreboard
// queue and an independent monitor compares every cycle's outputs against it.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [2:0]  rr1;
        logic [2:0]  rr2;
        logic [15:0] rs;
        logic [15:0] r2;
        logic [15:0] imm;
        logic [2:0]  w1;
        logic        reg_en;
        logic        mem_en;
        logic        mem_wr;
        logic        b_sel;
        logic [4:0]  alu_op;
    } idex_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  rr1;
        logic [2:0]  rr2;
        logic        u1;
        logic        u2;
        logic [15:0] rs;
        logic [15:0] r2;
        logic [15:0] imm;
        logic [2:0]  w1;
        logic        reg_en;
        logic        mem_en;
        logic        mem_wr;
        logic        b_sel;
        logic        halt;
        logic [4:0]  alu_op;
        logic        flush;
        logic        rst;
    } stim_t;

    typedef struct packed {
        idex_t       ex;
        logic        stall;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid_ID;
    logic [2:0]  read_reg1_ID;
    logic [2:0]  read_reg2_ID;
    logic        use_r1_ID;
    logic        use_r2_ID;
    logic [15:0] rs_ID;
    logic [15:0] r2_ID;
    logic [15:0] imm_ID;
    logic [2:0]  w1_reg_ID;
    logic        reg_en_ID;
    logic        mem_en_ID;
    logic        mem_wr_ID;
    logic        b_sel_ID;
    logic        halt_ID;
    logic [4:0]  alu_op_ID;
    logic        flush_EX;
    logic        valid_ID_EX;
    logic [2:0]  read_reg1_ID_EX;
    logic [2:0]  read_reg2_ID_EX;
    logic [15:0] rs_ID_EX;
    logic [15:0] r2_ID_EX;
    logic [15:0] imm_ID_EX;
    logic [2:0]  w1_reg_ID_EX;
    logic        reg_en_ID_EX;
    logic        mem_en_ID_EX;
    logic        mem_wr_ID_EX;
    logic        b_sel_ID_EX;
    logic [4:0]  alu_op_ID_EX;
    logic        stall;
    logic        halted;
    logic [15:0] stall_count;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];

    idex_t m_ex;
    logic  m_halted;
    int    m_cnt;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .valid_ID(valid_ID), .read_reg1_ID(read_reg1_ID), .read_reg2_ID(read_reg2_ID),
        .use_r1_ID(use_r1_ID), .use_r2_ID(use_r2_ID),
        .rs_ID(rs_ID), .r2_ID(r2_ID), .imm_ID(imm_ID), .w1_reg_ID(w1_reg_ID),
        .reg_en_ID(reg_en_ID), .mem_en_ID(mem_en_ID), .mem_wr_ID(mem_wr_ID),
        .b_sel_ID(b_sel_ID), .halt_ID(halt_ID), .alu_op_ID(alu_op_ID), .flush_EX(flush_EX),
        .valid_ID_EX(valid_ID_EX), .read_reg1_ID_EX(read_reg1_ID_EX),
        .read_reg2_ID_EX(read_reg2_ID_EX), .rs_ID_EX(rs_ID_EX), .r2_ID_EX(r2_ID_EX),
        .imm_ID_EX(imm_ID_EX), .w1_reg_ID_EX(w1_reg_ID_EX), .reg_en_ID_EX(reg_en_ID_EX),
        .mem_en_ID_EX(mem_en_ID_EX), .mem_wr_ID_EX(mem_wr_ID_EX), .b_sel_ID_EX(b_sel_ID_EX),
        .alu_op_ID_EX(alu_op_ID_EX),
        .stall(stall), .halted(halted), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input logic [2:0] a, input logic ua,
                                 input logic [2:0] b, input logic ub, input logic [2:0] w,
                                 input logic re, input logic me, input logic mw,
                                 input logic h, input logic fl, input logic r);
        stim_t s;
        s.valid = v;  s.rr1 = a;  s.u1 = ua;  s.rr2 = b;  s.u2 = ub;  s.w1 = w;
        s.reg_en = re; s.mem_en = me; s.mem_wr = mw; s.halt = h; s.flush = fl; s.rst = r;
        s.rs = 16'($urandom); s.r2 = 16'($urandom); s.imm = 16'($urandom);
        s.b_sel = 1'($urandom); s.alu_op = 5'($urandom);
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = mk($urandom_range(0, 7) != 0,
               3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
               3'($urandom_range(0, 3)),
               $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) < 3,
               $urandom_range(0, 79) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
        return s;
    endfunction

    // Drives one cycle of decode input, records what the outputs must look like this cycle,
    // then advances the reference pipeline by one edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        logic ld_in_ex;
        logic hazard;
        logic st;
        valid_ID = s.valid;  read_reg1_ID = s.rr1; read_reg2_ID = s.rr2;
        use_r1_ID = s.u1;    use_r2_ID = s.u2;     rs_ID = s.rs; r2_ID = s.r2;
        imm_ID = s.imm;      w1_reg_ID = s.w1;     reg_en_ID = s.reg_en;
        mem_en_ID = s.mem_en; mem_wr_ID = s.mem_wr; b_sel_ID = s.b_sel;
        halt_ID = s.halt;    alu_op_ID = s.alu_op; flush_EX = s.flush; rst = s.rst;

        ld_in_ex = m_ex.valid && m_ex.mem_en && !m_ex.mem_wr && m_ex.reg_en;
        hazard = s.valid && ld_in_ex &&
                 ((s.u1 && s.rr1 == m_ex.w1) || (s.u2 && s.rr2 == m_ex.w1));
        st = (hazard || m_halted) && !s.flush;

        e.ex = m_ex; e.stall = st; e.halted = m_halted; e.cnt = 16'(m_cnt);
        exp_q.push_back(e);

        if (s.rst) begin
            m_ex = '0; m_halted = 1'b0; m_cnt = 0;
        end else begin
            if (st && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (s.flush || m_halted || hazard) begin
                m_ex = '0;
            end else begin
                m_ex.valid  = s.valid;  m_ex.rr1 = s.rr1; m_ex.rr2 = s.rr2;
                m_ex.rs     = s.rs;     m_ex.r2  = s.r2;  m_ex.imm = s.imm; m_ex.w1 = s.w1;
                m_ex.reg_en = s.valid && s.reg_en;
                m_ex.mem_en = s.valid && s.mem_en;
                m_ex.mem_wr = s.valid && s.mem_wr;
                m_ex.b_sel  = s.valid && s.b_sel;
                m_ex.alu_op = s.valid ? s.alu_op : 5'd0;
                if (s.valid && s.halt) m_halted = 1'b1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input exp_t e);
        idex_t got;
        got = {valid_ID_EX, read_reg1_ID_EX, read_reg2_ID_EX, rs_ID_EX, r2_ID_EX, imm_ID_EX,
               w1_reg_ID_EX, reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX, b_sel_ID_EX, alu_op_ID_EX};
        checks++;
        if (got !== e.ex) begin
            errors++;
            $display("[TB] FAIL id_ex_regs at %0t: got %h expected %h", $time, got, e.ex);
        end
        checks++;
        if (stall !== e.stall) begin
            errors++;
            $display("[TB] FAIL stall at %0t: got %b expected %b", $time, stall, e.stall);
        end
        checks++;
        if (halted !== e.halted) begin
            errors++;
            $display("[TB] FAIL halted at %0t: got %b expected %b", $time, halted, e.halted);
        end
        checks++;
        if (stall_count !== e.cnt) begin
            errors++;
            $display("[TB] FAIL stall_count at %0t: got %h expected %h", $time, stall_count, e.cnt);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        stim_t nop;
        int drain;
        rst = 1'b1; valid_ID = 1'b0; read_reg1_ID = '0; read_reg2_ID = '0;
        use_r1_ID = 1'b0; use_r2_ID = 1'b0; rs_ID = '0; r2_ID = '0; imm_ID = '0;
        w1_reg_ID = '0; reg_en_ID = 1'b0; mem_en_ID = 1'b0; mem_wr_ID = 1'b0;
        b_sel_ID = 1'b0; halt_ID = 1'b0; alu_op_ID = '0; flush_EX = 1'b0;
        m_ex = '0; m_halted = 1'b0; m_cnt = 0;
        repeat (3) @(posedge clk);
        #2;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] directed: load-use on r1");
        applyStimulus(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 3, 1, 2, 0, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 3, 1, 2, 0, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus(nop);

        $display("[TB] directed: independent add after load");
        applyStimulus(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 4, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0));
        applyStimulus(nop);

        $display("[TB] directed: load-use with simultaneous flush");
        applyStimulus(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 1, 0));
        applyStimulus(nop);

        $display("[TB] directed: invalid slot with enables, r0 match, store data via r2");
        applyStimulus(mk(0, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 3, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 1, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 0, 1, 5, 0, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 0, 1, 5, 0, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0));
        applyStimulus(mk(1, 5, 1, 3, 0, 0, 0, 1, 1, 0, 0, 0));
        applyStimulus(nop);

        $display("[TB] directed: halt, flush while halted, reset out of halt");
        applyStimulus(mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (4) applyStimulus(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 1, 0));
        applyStimulus(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));
        applyStimulus(mk(1, 5, 1, 2, 1, 6, 1, 0, 0, 0, 0, 0));

        $display("[TB] random phase");
        for (int i = 0; i < 3000; i++) applyStimulus(rand_stim());

        $display("[TB] saturation phase");
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 65600; i++) applyStimulus(nop);
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        applyStimulus(mk(1, 2, 1, 3, 1, 4, 1, 0, 0, 0, 0, 0));
        applyStimulus(nop);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            #1;
            drain++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
